// File: rtl/arb_pkg.sv
// Shared definitions for the request arbiter.
// Holds the two-state FSM encoding and the default sizing constants
// used by req_arbiter_ctrl and its winner-selection sub-module.
package arb_pkg;

    localparam int ARB_N_DEF        = 4;   // number of requesters
    localparam int ARB_MAX_HOLD_DEF = 15;  // longest uninterrupted grant, in cycles
    localparam int ARB_CNT_W_DEF    = 8;   // conflict counter width

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection.
// Searches req for the first set bit at or after start_idx, wrapping from
// N-1 back to 0. Fixed priority is obtained with start_idx = 0.
// Ports:
//   req       - request vector, bit i = requester i
//   start_idx - index where the search begins
//   found     - at least one request is set
//   winner    - index of the selected requester (0 when found is low)
//   multi_hit - two or more requests are set
module arb_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start_idx,
    output logic             found,
    output logic [IDX_W-1:0] winner,
    output logic             multi_hit
);

    // Rotating priority search; the first hit from start_idx wins.
    always_comb begin
        int k_v;
        found  = 1'b0;
        winner = '0;
        k_v    = 0;
        for (int i = 0; i < N; i++) begin
            k_v = int'(start_idx) + i;
            if (k_v >= N) begin
                k_v = k_v - N;
            end else begin
                k_v = k_v;
            end
            if (!found && req[k_v[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = k_v[IDX_W-1:0];
            end else begin
                found  = found;
            end
        end
    end

    // Conflict detection is independent of which requester wins.
    always_comb begin
        multi_hit = ($countones(req) > 32'sd1);
    end

endmodule

// File: rtl/req_arbiter_ctrl.sv
// Request arbiter with fixed-priority or round-robin selection.
// A grant is held while the owner keeps requesting, up to MAX_HOLD cycles,
// after which it is revoked with a timeout pulse. Every grant is followed by
// at least one idle cycle before the next arbitration.
// Ports:
//   clk          - clock, all state on the rising edge
//   rst          - synchronous active-high reset
//   req          - request vector, bit i = requester i
//   rr_mode      - 0 fixed priority (lowest index), 1 round-robin
//   gnt          - registered one-hot grant, or zero
//   busy         - high while a grant is held
//   multi_match  - pulse: the arbitration that raised gnt saw >= 2 requesters
//   timeout      - pulse: a grant was revoked at MAX_HOLD
//   conflict_cnt - saturating count of multi_match pulses
module req_arbiter_ctrl
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int CNT_W    = ARB_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             rr_mode,
    output logic [N-1:0]     gnt,
    output logic             busy,
    output logic             multi_match,
    output logic             timeout,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int IDX_W  = $clog2(N);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_e        state_r;
    logic [N-1:0]      gnt_r;
    logic [IDX_W-1:0]  owner_r;
    logic [IDX_W-1:0]  rr_ptr_r;
    logic [HOLD_W-1:0] hold_r;
    logic              mm_r;
    logic              to_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [IDX_W-1:0]  start_s;
    logic              found_s;
    logic [IDX_W-1:0]  winner_s;
    logic              multi_s;
    logic [IDX_W-1:0]  next_ptr_s;
    logic              owner_req_s;

    function automatic logic [N-1:0] onehot_f(input logic [IDX_W-1:0] idx);
        logic [N-1:0] v;
        v = {{(N-1){1'b0}}, 1'b1};
        return v << idx;
    endfunction

    // Search start: rr pointer in round-robin mode, index 0 otherwise.
    always_comb begin
        if (rr_mode) begin
            start_s = rr_ptr_r;
        end else begin
            start_s = '0;
        end
    end

    // Pointer after a grant is winner+1 modulo N (N need not be a power of 2).
    always_comb begin
        if (winner_s == IDX_W'(N - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = winner_s + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

    // Only the current owner's request line matters while granted.
    always_comb begin
        owner_req_s = req[owner_r];
    end

    arb_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (req),
        .start_idx (start_s),
        .found     (found_s),
        .winner    (winner_s),
        .multi_hit (multi_s)
    );

    // Arbitration FSM, hold counter, pulses and conflict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            gnt_r    <= '0;
            owner_r  <= '0;
            rr_ptr_r <= '0;
            hold_r   <= '0;
            mm_r     <= 1'b0;
            to_r     <= 1'b0;
            cnt_r    <= '0;
        end else begin
            mm_r <= 1'b0;
            to_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        gnt_r   <= onehot_f(winner_s);
                        owner_r <= winner_s;
                        hold_r  <= {{(HOLD_W-1){1'b0}}, 1'b1};
                        state_r <= ST_GRANT;
                        mm_r    <= multi_s;
                        if (multi_s && (cnt_r != {CNT_W{1'b1}})) begin
                            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        // Pointer moves past the winner, so a later timeout
                        // already leaves the revoked owner at lowest priority.
                        if (rr_mode) begin
                            rr_ptr_r <= next_ptr_s;
                        end
                    end else begin
                        gnt_r  <= '0;
                        hold_r <= '0;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req_s) begin
                        gnt_r   <= '0;
                        hold_r  <= '0;
                        state_r <= ST_IDLE;
                    end else if (hold_r == HOLD_W'(MAX_HOLD)) begin
                        gnt_r   <= '0;
                        hold_r  <= '0;
                        to_r    <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        hold_r <= hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    gnt_r   <= '0;
                    hold_r  <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt          = gnt_r;
    assign busy         = (state_r == ST_GRANT);
    assign multi_match  = mm_r;
    assign timeout      = to_r;
    assign conflict_cnt = cnt_r;

endmodule

// File: tb/tb_req_arbiter_ctrl.sv
// Directed testbench for req_arbiter_ctrl. A default-sized instance covers
// the functional scenarios; a second instance with a 2-bit conflict counter
// shares the same stimulus and covers counter saturation.
module tb_req_arbiter_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rr_mode;

    logic [3:0] gnt;
    logic       busy;
    logic       mm;
    logic       to;
    logic [7:0] cnt;

    logic [3:0] gnt2;
    logic       busy2;
    logic       mm2;
    logic       to2;
    logic [1:0] cnt2;

    int n_total;
    int n_bad;

    logic [1:0] sat_exp [5];
    logic [3:0] rr_exp  [5];

    req_arbiter_ctrl #(.N(4), .MAX_HOLD(15), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .rr_mode      (rr_mode),
        .gnt          (gnt),
        .busy         (busy),
        .multi_match  (mm),
        .timeout      (to),
        .conflict_cnt (cnt)
    );

    req_arbiter_ctrl #(.N(4), .MAX_HOLD(15), .CNT_W(2)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .rr_mode      (rr_mode),
        .gnt          (gnt2),
        .busy         (busy2),
        .multi_match  (mm2),
        .timeout      (to2),
        .conflict_cnt (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    // Grant must never be multi-hot in either instance.
    always @(negedge clk) begin
        chk("onehot", {31'd0, $onehot0(gnt)}, 32'd1);
        chk("onehot2", {31'd0, $onehot0(gnt2)}, 32'd1);
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst     = 1'b1;
        req     = 4'b0000;
        rr_mode = 1'b0;
        cyc(2);

        // Reset state
        chk("rst_gnt", gnt, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_mm", mm, 32'h0);
        chk("rst_to", to, 32'h0);
        chk("rst_cnt", cnt, 32'h0);
        chk("rst_cnt2", cnt2, 32'h0);
        rst = 1'b0;

        // Saturation: five two-requester arbitrations
        for (int i = 0; i < 5; i++) begin
            req = 4'b0011;
            cyc(1);
            chk("sat_gnt", gnt, 32'h1);
            chk("sat_cnt2", cnt2, sat_exp[i]);
            req = 4'b0000;
            cyc(1);
        end
        chk("sat_cnt8", cnt, 32'd5);

        // Fixed priority, req 0110 for three cycles
        do_reset();
        rr_mode = 1'b0;
        req = 4'b0110;
        cyc(1);
        chk("fix_gnt", gnt, 32'h2);
        chk("fix_busy", busy, 32'h1);
        chk("fix_mm", mm, 32'h1);
        chk("fix_cnt", cnt, 32'h1);
        cyc(1);
        chk("fix_gnt_h1", gnt, 32'h2);
        chk("fix_mm_low", mm, 32'h0);
        req = 4'b0111;  // extra non-owner request during GRANT
        cyc(1);
        chk("fix_gnt_h2", gnt, 32'h2);
        chk("fix_cnt_h2", cnt, 32'h1);
        req = 4'b0000;
        cyc(1);
        chk("fix_rel_gnt", gnt, 32'h0);
        chk("fix_rel_busy", busy, 32'h0);
        chk("fix_rel_cnt", cnt, 32'h1);

        // Round-robin rotation with all four requesting
        do_reset();
        rr_mode = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("rr_gnt", gnt, rr_exp[i]);
            chk("rr_mm", mm, 32'h1);
            chk("rr_cnt", cnt, i + 1);
            cyc(1);
            chk("rr_hold", gnt, rr_exp[i]);
            req = 4'b1111 & ~rr_exp[i];
            cyc(1);
            chk("rr_rel", gnt, 32'h0);
            req = 4'b1111;
        end

        // Timeout in fixed mode: 15 granted cycles, one idle, re-grant
        do_reset();
        rr_mode = 1'b0;
        req = 4'b0001;
        cyc(1);
        chk("to_gnt1", gnt, 32'h1);
        for (int i = 0; i < 14; i++) begin
            cyc(1);
            chk("to_hold", gnt, 32'h1);
            chk("to_early", to, 32'h0);
        end
        cyc(1);
        chk("to_rev_gnt", gnt, 32'h0);
        chk("to_pulse", to, 32'h1);
        chk("to_busy", busy, 32'h0);
        cyc(1);
        chk("to_regnt", gnt, 32'h1);
        chk("to_pulse_end", to, 32'h0);
        chk("to_mm", mm, 32'h0);

        // Timeout in round-robin mode: revoked owner goes to lowest priority
        do_reset();
        rr_mode = 1'b1;
        req = 4'b0011;
        cyc(1);
        chk("rrto_gnt", gnt, 32'h1);
        cyc(14);
        cyc(1);
        chk("rrto_pulse", to, 32'h1);
        cyc(1);
        chk("rrto_next", gnt, 32'h2);

        // Reset while 0100 is granted
        do_reset();
        rr_mode = 1'b1;
        req = 4'b1100;
        cyc(1);
        chk("rg_gnt", gnt, 32'h4);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk("rg_gnt0", gnt, 32'h0);
        chk("rg_busy", busy, 32'h0);
        chk("rg_cnt", cnt, 32'h0);
        chk("rg_to", to, 32'h0);
        rst = 1'b0;
        cyc(1);
        chk("rg_rr_first", gnt, 32'h4);
        rst = 1'b1;
        cyc(1);
        rr_mode = 1'b0;
        rst = 1'b0;
        cyc(1);
        chk("rg_fix_first", gnt, 32'h4);

        // rr_mode toggled mid-GRANT
        do_reset();
        rr_mode = 1'b1;
        req = 4'b0011;
        cyc(1);
        chk("tg_gnt", gnt, 32'h1);
        rr_mode = 1'b0;
        cyc(1);
        chk("tg_owner", gnt, 32'h1);
        req = 4'b0010;
        cyc(1);
        chk("tg_rel", gnt, 32'h0);
        req = 4'b0011;
        cyc(1);
        chk("tg_fixed", gnt, 32'h1);
        req = 4'b0010;
        cyc(1);
        chk("tg_rel2", gnt, 32'h0);
        rr_mode = 1'b1;
        req = 4'b0011;
        cyc(1);
        chk("tg_rr_ptr", gnt, 32'h2);

        req = 4'b0000;
        cyc(2);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
